// File: rtl/cipher_pkg.sv
// Shared constants and types for the cipher round sequencer and its datapath.
package cipher_pkg;

  localparam int ROUND_W_DEF    = 4;
  localparam int MAX_ROUNDS_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  typedef logic [ROUND_W_DEF-1:0] round_idx_t;

  function automatic int clamp_rounds(input int cfg, input int max_rounds);
    return (cfg > max_rounds) ? max_rounds : cfg;
  endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Handshake bundle between the round sequencer (master) and the host/datapath side (slave).
// The abort input exists only when ROUND_SEQUENCER_ABORT_EN is defined.
interface round_sequencer_if
  import cipher_pkg::*;
#(
  parameter int ROUND_W = ROUND_W_DEF
);
  logic               start;
  logic [ROUND_W-1:0] rounds_cfg;
  logic               decrypt;
  logic               dp_ready;
`ifdef ROUND_SEQUENCER_ABORT_EN
  logic               abort;
`endif
  logic               busy;
  logic               load_key;
  logic               round_en;
  logic [ROUND_W-1:0] round_idx;
  logic               last_round;
  logic               done;

`ifdef ROUND_SEQUENCER_ABORT_EN
  modport master (
    input  start, rounds_cfg, decrypt, dp_ready, abort,
    output busy, load_key, round_en, round_idx, last_round, done
  );
  modport slave (
    output start, rounds_cfg, decrypt, dp_ready, abort,
    input  busy, load_key, round_en, round_idx, last_round, done
  );
`else
  modport master (
    input  start, rounds_cfg, decrypt, dp_ready,
    output busy, load_key, round_en, round_idx, last_round, done
  );
  modport slave (
    output start, rounds_cfg, decrypt, dp_ready,
    input  busy, load_key, round_en, round_idx, last_round, done
  );
`endif

endinterface

// File: rtl/round_idx_cnt.sv
// Loadable up/down counter for the round index; saturates at its terminal value
// (0 when counting down, limit when counting up).
module round_idx_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         down,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         term
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign term = down ? (cnt_q == '0) : (cnt_q == limit);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && !term) begin
      cnt_d = down ? (cnt_q - W'(1)) : (cnt_q + W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Cipher round sequencer: start -> key load -> N rounds (ascending or descending index) -> done.
// Defining ROUND_SEQUENCER_ABORT_EN adds an abort input that cancels a sequence in LOAD/RUN.
module round_sequencer
  import cipher_pkg::*;
#(
  parameter int ROUND_W    = ROUND_W_DEF,
  parameter int MAX_ROUNDS = MAX_ROUNDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  round_sequencer_if.master bus
);

  seq_state_t         state_q, state_d;
  logic [ROUND_W-1:0] n_q, n_d;
  logic               dec_q, dec_d;
  logic [ROUND_W-1:0] rem_q, rem_d;
  logic               load_key_q, load_key_d;
  logic               done_q, done_d;

  logic               cnt_clear;
  logic               cnt_load;
  logic [ROUND_W-1:0] cnt_load_val;
  logic               cnt_en;
  logic [ROUND_W-1:0] idx;
  logic               idx_term;
  logic               round_en;
  logic               last_round;
  logic               abort_req;

`ifdef ROUND_SEQUENCER_ABORT_EN
  assign abort_req = bus.abort && ((state_q == LOAD) || (state_q == RUN));
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    dec_d        = dec_q;
    rem_d        = rem_q;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    round_en     = 1'b0;
    last_round   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.rounds_cfg != '0) begin
            n_d     = ROUND_W'(clamp_rounds(int'(bus.rounds_cfg), MAX_ROUNDS));
            dec_d   = bus.decrypt;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        cnt_load     = 1'b1;
        cnt_load_val = dec_q ? (n_q - ROUND_W'(1)) : '0;
        rem_d        = n_q;
        state_d      = RUN;
      end
      RUN: begin
        last_round = (rem_q == ROUND_W'(1));
        round_en   = bus.dp_ready;
        if (bus.dp_ready) begin
          rem_d = rem_q - ROUND_W'(1);
          // The final round leaves the index parked on its last value.
          if (rem_q == ROUND_W'(1)) begin
            state_d = DONE;
          end else begin
            cnt_en = !idx_term;
          end
        end
      end
      DONE: begin
        cnt_clear = 1'b1;
        n_d       = '0;
        dec_d     = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort_req) begin
      state_d   = IDLE;
      n_d       = '0;
      dec_d     = 1'b0;
      rem_d     = '0;
      cnt_clear = 1'b1;
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;
      round_en  = 1'b0;
    end

    load_key_d = (state_d == LOAD);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      dec_q      <= 1'b0;
      rem_q      <= '0;
      load_key_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      dec_q      <= dec_d;
      rem_q      <= rem_d;
      load_key_q <= load_key_d;
      done_q     <= done_d;
    end
  end

  round_idx_cnt #(.W(ROUND_W)) u_idx_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .down     (dec_q),
    .limit    (n_q - ROUND_W'(1)),
    .cnt      (idx),
    .term     (idx_term)
  );

  assign bus.busy       = (state_q != IDLE);
  assign bus.load_key   = load_key_q;
  assign bus.round_en   = round_en;
  assign bus.round_idx  = idx;
  assign bus.last_round = last_round;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: per-cycle comparison against a round-counting model,
// directed sequences pinned with literal expectations, then randomized traffic.
module tb_round_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic abort_req = 1'b0;

  always #5 clk = ~clk;

  round_sequencer_if #(.ROUND_W(4)) sif ();

  round_sequencer #(.ROUND_W(4), .MAX_ROUNDS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

`ifdef ROUND_SEQUENCER_ABORT_EN
  assign sif.abort = abort_req;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: a sequence is "age" cycles old and has executed k of n rounds.
  bit m_active = 1'b0;
  bit m_dec = 1'b0;
  int m_n = 0;
  int m_age = 0;
  int m_k = 0;

  logic hist_busy [32];
  logic hist_load [32];
  logic hist_en   [32];
  logic hist_last [32];
  logic hist_done [32];
  int   hist_idx  [32];

  always @(posedge clk) begin : model_update
    bit in_done;
    int cfg;
    in_done = (m_n == 0) || (m_age >= 2 && m_k == m_n);
    cfg = int'(sif.rounds_cfg);
    if (!rst) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (sif.start) begin
        m_active <= 1'b1;
        m_age    <= 1;
        m_k      <= 0;
        m_dec    <= sif.decrypt;
        m_n      <= (cfg > 10) ? 10 : cfg;
      end
    end else if (in_done) begin
      m_active <= 1'b0;
    end else if (abort_req) begin
`ifdef ROUND_SEQUENCER_ABORT_EN
      m_active <= 1'b0;
`else
      m_age <= m_age + 1;
      if (m_age >= 2 && sif.dp_ready) m_k <= m_k + 1;
`endif
    end else begin
      m_age <= m_age + 1;
      if (m_age >= 2 && sif.dp_ready) m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin : compare
    logic e_busy, e_load, e_en, e_last, e_done;
    int e_idx;
    bit abrt;
    if (chk_en) begin
      e_busy = 0; e_load = 0; e_en = 0; e_last = 0; e_done = 0; e_idx = 0;
`ifdef ROUND_SEQUENCER_ABORT_EN
      abrt = abort_req;
`else
      abrt = 1'b0;
`endif
      if (m_active) begin
        e_busy = 1;
        if ((m_n == 0) || (m_age >= 2 && m_k == m_n)) begin
          e_done = 1;
          e_idx  = (m_n == 0 || m_dec) ? 0 : m_n - 1;
        end else if (m_age == 1) begin
          e_load = 1;
        end else begin
          e_idx  = m_dec ? (m_n - 1 - m_k) : m_k;
          e_last = (m_k == m_n - 1);
          e_en   = sif.dp_ready && !abrt;
        end
      end
      vectors++;
      if (sif.busy !== e_busy || sif.load_key !== e_load || sif.round_en !== e_en ||
          int'(sif.round_idx) !== e_idx || sif.last_round !== e_last || sif.done !== e_done) begin
        miscompares++;
        $display("FAIL model_cycle t=%0t: got busy=%b load=%b en=%b idx=%0d last=%b done=%b, want busy=%b load=%b en=%b idx=%0d last=%b done=%b",
                 $time, sif.busy, sif.load_key, sif.round_en, sif.round_idx, sif.last_round, sif.done,
                 e_busy, e_load, e_en, e_idx, e_last, e_done);
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step(input int c, input logic s, input logic [3:0] cfg, input logic d,
                      input logic rdy, input logic r, input logic ab);
    sif.start      = s;
    sif.rounds_cfg = cfg;
    sif.decrypt    = d;
    sif.dp_ready   = rdy;
    rst            = r;
    abort_req      = ab;
    @(negedge clk);
    if (c >= 0 && c < 32) begin
      hist_busy[c] = sif.busy;
      hist_load[c] = sif.load_key;
      hist_en[c]   = sif.round_en;
      hist_last[c] = sif.last_round;
      hist_done[c] = sif.done;
      hist_idx[c]  = int'(sif.round_idx);
    end
    @(posedge clk);
    #1;
  endtask

  // One sequence started at cycle 0; -1 disables the optional events.
  task automatic seq(input logic [3:0] cfg, input logic d, input int len, input int stall_lo,
                     input int stall_hi, input int rst_at, input int restart_at, input int abort_at);
    for (int c = 0; c < len; c++) begin
      step(c, (c == 0) || (c == restart_at), (c == 0) ? cfg : 4'(c + 5), d,
           !(c >= stall_lo && c <= stall_hi), (c != rst_at), (c == abort_at));
    end
  endtask

  int exp_enc[4] = '{0, 1, 2, 3};
  int exp_dec[3] = '{2, 1, 0};
  int done_cnt;

  initial begin
    sif.start = 0; sif.rounds_cfg = 0; sif.decrypt = 0; sif.dp_ready = 1;
    @(posedge clk); #1;
    step(-1, 0, 0, 0, 1, 0, 0);
    step(-1, 0, 0, 0, 1, 0, 0);
    chk_en = 1'b1;

    // Encrypt N=4
    seq(4'd4, 0, 10, -1, -1, -1, -1, -1);
    lit("reset_busy", hist_busy[0], 0);
    lit("reset_idx", hist_idx[0], 0);
    lit("reset_done", hist_done[0], 0);
    lit("enc_load_c1", hist_load[1], 1);
    for (int i = 0; i < 4; i++) lit("enc_idx", hist_idx[i + 2], exp_enc[i]);
    lit("enc_last_c4", hist_last[4], 0);
    lit("enc_last_c5", hist_last[5], 1);
    lit("enc_done_c6", hist_done[6], 1);
    lit("enc_busy_c7", hist_busy[7], 0);

    // Decrypt N=3
    seq(4'd3, 1, 8, -1, -1, -1, -1, -1);
    for (int i = 0; i < 3; i++) lit("dec_idx", hist_idx[i + 2], exp_dec[i]);
    lit("dec_done_c5", hist_done[5], 1);

    // Stall N=2, dp_ready low in cycles 2-3
    seq(4'd2, 0, 9, 2, 3, -1, -1, -1);
    lit("stall_en_c2", hist_en[2], 0);
    lit("stall_idx_c3", hist_idx[3], 0);
    lit("stall_en_c4", hist_en[4], 1);
    lit("stall_idx_c5", hist_idx[5], 1);
    lit("stall_done_c6", hist_done[6], 1);

    // Zero rounds
    seq(4'd0, 0, 4, -1, -1, -1, -1, -1);
    lit("zero_done_c1", hist_done[1], 1);
    lit("zero_load_c1", hist_load[1], 0);
    lit("zero_en_c1", hist_en[1], 0);

    // Clamp 15 -> 10
    seq(4'd15, 0, 15, -1, -1, -1, -1, -1);
    lit("clamp_idx_c11", hist_idx[11], 9);
    lit("clamp_last_c11", hist_last[11], 1);
    lit("clamp_done_c11", hist_done[11], 0);
    lit("clamp_done_c12", hist_done[12], 1);

    // Reset mid-run (N=5, rst low in cycle 3)
    seq(4'd5, 0, 12, -1, -1, 3, -1, -1);
    done_cnt = 0;
    for (int c = 4; c < 12; c++) done_cnt += int'(hist_done[c]);
    lit("rst_busy_c4", hist_busy[4], 0);
    lit("rst_idx_c4", hist_idx[4], 0);
    lit("rst_no_done", done_cnt, 0);
    seq(4'd2, 1, 7, -1, -1, -1, -1, -1);
    lit("post_rst_idx_c2", hist_idx[2], 1);
    lit("post_rst_done_c4", hist_done[4], 1);

    // Start while busy is ignored
    seq(4'd3, 0, 9, -1, -1, -1, 3, -1);
    lit("busy_start_idx_c4", hist_idx[4], 2);
    lit("busy_start_done_c5", hist_done[5], 1);
    lit("busy_start_idle_c6", hist_busy[6], 0);

`ifdef ROUND_SEQUENCER_ABORT_EN
    seq(4'd5, 0, 10, -1, -1, -1, -1, 3);
    done_cnt = 0;
    for (int c = 4; c < 10; c++) done_cnt += int'(hist_done[c]);
    lit("abort_en_c3", hist_en[3], 0);
    lit("abort_busy_c4", hist_busy[4], 0);
    lit("abort_no_done", done_cnt, 0);
`endif

    for (int i = 0; i < 800; i++) begin
      step(-1, ($urandom % 5) == 0, 4'($urandom), 1'($urandom), ($urandom % 4) != 0,
           ($urandom % 90) != 0, ($urandom % 30) == 0);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Initiator side of the cipher iteration protocol.
- Accepts a start request and a round count, drives the key load and per-round enables into the cipher datapath, and tracks the round index.
- Emits a one-cycle done pulse when the final round has executed.
- Supports encrypt order (index counts up) and decrypt order (index counts down), so one block serves both cipher directions.

Parameters:
- ROUND_W, 4: width of the round count and round index.
- MAX_ROUNDS, 10: upper bound on rounds. A configured count above this is clamped to MAX_ROUNDS.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  active-low synchronous reset.
- start  in  1  one-cycle request to begin a sequence; sampled only in IDLE.
- rounds_cfg  in  ROUND_W  number of rounds; latched on an accepted start.
- decrypt  in  1  0 = index ascending, 1 = index descending; latched on an accepted start.
- dp_ready  in  1  datapath can accept a round this cycle.
- busy  out  1  high in every state except IDLE.
- load_key  out  1  one-cycle key/state load strobe.
- round_en  out  1  a round executes this cycle.
- round_idx  out  ROUND_W  index of the current round.
- last_round  out  1  current round is the final one.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset and clock:
  - Reset is synchronous, active-low, on clk.
  - While rst=0, on the next edge: state=IDLE, all outputs 0, internal remaining count 0.
  - Reset asserted mid-sequence aborts the sequence with no done pulse.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 and rounds_cfg≥1: latch N=min(rounds_cfg, MAX_ROUNDS) and latch decrypt; go to LOAD.
  - start=1 and rounds_cfg=0: go directly to DONE; no load_key, no round_en.
  - start=0: stay in IDLE.
- LOAD:
  - load_key=1 for exactly one cycle.
  - round_idx set to 0 (encrypt) or N-1 (decrypt); remaining=N.
  - Next state is always RUN.
- RUN:
  - round_en = dp_ready, combinational from the registered state.
  - last_round = (remaining==1).
  - On a cycle with dp_ready=1:
    - remaining decrements.
    - round_idx steps +1 (encrypt) or -1 (decrypt).
    - If remaining was 1, go to DONE and hold round_idx at its final value; otherwise stay in RUN.
  - On a cycle with dp_ready=0: hold all state.
- DONE:
  - done=1 for exactly one cycle; next state IDLE.
  - round_idx returns to 0 on entry to IDLE.
- start while busy is ignored; it is not queued.
- Index wrap:
  - Encrypt: round_idx never exceeds N-1.
  - Decrypt: round_idx never goes below 0; the final round is index 0 and no decrement follows it.
- Latency with dp_ready held high:
  - start accepted at cycle 0.
  - load_key at cycle 1.
  - Rounds execute in cycles 2..N+1.
  - done at cycle N+2.
- Timing:
  - State, round_idx, load_key and done are registered.
  - round_en and last_round are decoded from registered state only.
  - No combinational path from start to any output.

Optional Feature:
- Macro: ROUND_SEQUENCER_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 in LOAD or RUN returns the block to IDLE on the next edge.
  - No done pulse, round_en=0 from that cycle, and latched config is cleared.
  - abort in IDLE or DONE has no effect.
- When undefined: no abort port; sequences always run to completion.

Decomposition:
- Shared package cipher_pkg holds:
  - ROUND_W_DEF and MAX_ROUNDS_DEF constants.
  - Typedef seq_state_t, an enum of IDLE, LOAD, RUN, DONE.
  - Typedef round_idx_t, logic [ROUND_W-1:0].
- Sub-module round_idx_cnt: loadable up/down counter with enable, direction input and a terminal flag.
  - Instantiated once for round_idx.
  - The remaining count is kept inside the FSM.

Test Plan:
- Encrypt, N=4: start with rounds_cfg=4, decrypt=0, dp_ready=1.
  - load_key at cycle 1.
  - round_idx 0,1,2,3 in cycles 2–5; last_round only at cycle 5.
  - done at cycle 6; busy low at cycle 7.
- Decrypt, N=3: rounds_cfg=3, decrypt=1.
  - round_idx 2,1,0 in cycles 2–4; done at cycle 5.
- Stall: N=2 with dp_ready low at cycles 2–3.
  - round_en=0 and round_idx holds 0 during the stall.
  - Rounds execute at cycles 4–5; done at cycle 6.
- Edge config, rounds_cfg=0: done at cycle 1; load_key and round_en never assert.
- Edge config, rounds_cfg=15: clamped to 10 rounds; done at cycle 12.
- Reset mid-RUN: rst low at cycle 3 of an N=5 run.
  - All outputs 0 after that edge; no done pulse.
  - A new start after reset behaves normally.
- With ROUND_SEQUENCER_ABORT_EN defined: abort at cycle 3 of an N=5 run gives IDLE at cycle 4 with no done pulse.
- Start while busy: start pulsed during RUN is ignored; the running sequence completes unchanged.
